// File: rtl/shared_divider.sv
// Sequential unsigned restoring divider shared on the bike-computer divider bus.
// One quotient bit per clock. busy/ready level handshake driven by a held start_div.
// Optional round-half-up stage enabled by defining SHARED_DIVIDER_ROUND_EN.
module shared_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] dividerbus,
    input  logic               start_div,
    output logic [WIDTH-1:0]   dividerres,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               ready,
    output logic               div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef SHARED_DIVIDER_ROUND_EN
        ROUND = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder, always < divisor between steps
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last;

    assign dividend = dividerbus[2*WIDTH-1:WIDTH];
    assign divisor  = dividerbus[WIDTH-1:0];

    // One restoring step: shift remainder/dividend left, subtract divisor when it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        // Top bit set means shifted exceeds any WIDTH-bit divisor; the WIDTH-bit
        // difference is still exact because the true result is below the divisor.
        fits     = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs_q);
        rem_next = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
        last     = (count == CW'(1));
    end

`ifdef SHARED_DIVIDER_ROUND_EN
    logic round_up;

    // Round half up on the truncated result; divide-by-zero and all-ones are left alone.
    always_comb begin
        round_up = !div_zero
                 && ({remainder, 1'b0} >= {1'b0, dvs_q})
                 && (dividerres != '1);
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (start_div) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
`ifdef SHARED_DIVIDER_ROUND_EN
                    state_next = ROUND;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SHARED_DIVIDER_ROUND_EN
            ROUND: begin
                busy       = 1'b1;
                state_next = DONE;
            end
`endif
            DONE: begin
                ready = 1'b1;
                if (!start_div) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            count      <= '0;
            dividerres <= '0;
            remainder  <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_div) begin
                        quo_q    <= dividend;
                        dvs_q    <= divisor;
                        rem_q    <= '0;
                        count    <= CW'(WIDTH);
                        div_zero <= (divisor == '0);
                    end
                end
                RUN: begin
                    quo_q <= quo_next;
                    rem_q <= rem_next;
                    count <= count - CW'(1);
                    if (last) begin
                        dividerres <= quo_next;
                        remainder  <= rem_next;
                    end
                end
`ifdef SHARED_DIVIDER_ROUND_EN
                ROUND: begin
                    if (round_up) dividerres <= dividerres + WIDTH'(1);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_divider.sv
// Self-checking bench for shared_divider against a plain-arithmetic reference model.
module tb_shared_divider;

    localparam int WIDTH = 16;
`ifdef SHARED_DIVIDER_ROUND_EN
    localparam int EXP_LAT  = WIDTH + 2;
    localparam int EXP_BUSY = WIDTH + 1;
`else
    localparam int EXP_LAT  = WIDTH + 1;
    localparam int EXP_BUSY = WIDTH;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [2*WIDTH-1:0] dividerbus;
    logic               start_div;
    logic [WIDTH-1:0]   dividerres;
    logic [WIDTH-1:0]   remainder;
    logic               busy;
    logic               ready;
    logic               div_zero;

    int checks = 0;
    int errors = 0;

    shared_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dividerbus (dividerbus),
        .start_div  (start_div),
        .dividerres (dividerres),
        .remainder  (remainder),
        .busy       (busy),
        .ready      (ready),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    // Reference: integer division with optional round-half-up.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                  output logic dz);
        int unsigned qa, ra;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            qa = int'(a) / int'(b);
            ra = int'(a) % int'(b);
`ifdef SHARED_DIVIDER_ROUND_EN
            if (2 * ra >= int'(b) && qa != 32'hFFFF) qa = qa + 1;
`endif
            q = WIDTH'(qa); r = WIDTH'(ra); dz = 1'b0;
        end
    endfunction

    // Issue a request and hold it; returns edges to ready (accepting edge = 1) and busy cycles.
    task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        dividerbus = {a, b};
        start_div  = 1'b1;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (ready) begin lat = i; break; end
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        start_div = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_result(input string name, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input int lat, input int bcnt);
        logic [WIDTH-1:0] eq, er;
        logic edz;
        model(a, b, eq, er, edz);
        checks++;
        if (lat !== EXP_LAT || bcnt !== EXP_BUSY || dividerres !== eq ||
            remainder !== er || div_zero !== edz) begin
            errors++;
            $display("FAIL %s a=%0d b=%0d: got q=%0d r=%0d dz=%0b lat=%0d busy=%0d, want q=%0d r=%0d dz=%0b lat=%0d busy=%0d",
                     name, a, b, dividerres, remainder, div_zero, lat, bcnt,
                     eq, er, edz, EXP_LAT, EXP_BUSY);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_div = 1'b0; dividerbus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || ready !== 1'b0 || dividerres !== '0 ||
                remainder !== '0 || div_zero !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: busy=%b ready=%b q=%0d r=%0d dz=%b, want all 0",
                         i, busy, ready, dividerres, remainder, div_zero);
            end
        end
    endtask

    task automatic test_directed();
        logic [2*WIDTH-1:0] vec [5];
        int lat, bcnt;
        vec[0] = {16'd1000, 16'd7};
        vec[1] = {16'd500,  16'd0};
        vec[2] = {16'd5,    16'd10};
        vec[3] = {16'hFFFF, 16'd1};
        vec[4] = {16'd0,    16'd9};
        foreach (vec[k]) begin
            do_div(vec[k][2*WIDTH-1:WIDTH], vec[k][WIDTH-1:0], lat, bcnt);
            check_result("directed", vec[k][2*WIDTH-1:WIDTH], vec[k][WIDTH-1:0], lat, bcnt);
            release_req();
        end
    endtask

    task automatic test_handshake();
        int lat, bcnt;
        logic [WIDTH-1:0] held;
        do_div(16'd1234, 16'd10, lat, bcnt);
        check_result("hs_first", 16'd1234, 16'd10, lat, bcnt);
        held = dividerres;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b1 || busy !== 1'b0 || dividerres !== held) begin
                errors++;
                $display("FAIL hs_hold cyc%0d: ready=%b busy=%b q=%0d, want ready=1 busy=0 q=%0d",
                         i, ready, busy, dividerres, held);
            end
        end
        release_req();
        checks++;
        if (ready !== 1'b0 || dividerres !== held) begin
            errors++;
            $display("FAIL hs_drop: ready=%b q=%0d, want ready=0 q=%0d", ready, dividerres, held);
        end
        do_div(16'd100, 16'd3, lat, bcnt);
        check_result("hs_reassert", 16'd100, 16'd3, lat, bcnt);
        release_req();
    endtask

    // Drop start_div mid-run: completes, ready for one cycle only.
    task automatic test_early_drop();
        int lat = -1;
        @(negedge clk);
        dividerbus = {16'd999, 16'd13};
        start_div  = 1'b1;
        @(negedge clk);
        start_div  = 1'b0;
        dividerbus = {16'd7, 16'd2};
        for (int i = 2; i <= 60; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; break; end
            dividerbus = {16'($urandom), 16'($urandom)};
        end
        check_result("drop_and_op_change", 16'd999, 16'd13, lat, EXP_BUSY);
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle_ready: ready=%b busy=%b, want 0 0", ready, busy);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [WIDTH-1:0] a, b;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            do_div(a, b, lat, bcnt);
            check_result("random", a, b, lat, bcnt);
            release_req();
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        @(negedge clk);
        dividerbus = {16'd500, 16'd0};
        start_div  = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || dividerres !== '0 ||
            remainder !== '0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ready=%b q=%0d r=%0d dz=%b, want all 0",
                     busy, ready, dividerres, remainder, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1; start_div = 1'b0;
        do_div(16'd1000, 16'd7, lat, bcnt);
        check_result("after_reset_mid", 16'd1000, 16'd7, lat, bcnt);
        release_req();
    endtask

    initial begin
        test_reset();
        // Preload a non-zero result so the mid-run reset check has something to clear.
        test_directed();
        test_handshake();
        test_early_drop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_divider.md
Name: shared_divider

Overview:
- Sequential unsigned restoring divider shared by the speed and average-speed stages of the bike computer. It sits directly downstream of the speed block on the divider bus.
- Takes the dividend (circumference × constant) and the divisor (reed period count), and returns the quotient as the speed value.
- Produces one quotient bit per clock. Handshake is Busy/Ready level signalling driven by a held start request.

Parameters:
- WIDTH, 16, operand and quotient width in bits; the divider bus is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- dividerbus  input  2*WIDTH  operands: [2*WIDTH-1:WIDTH] is the dividend, [WIDTH-1:0] is the divisor.
- start_div  input  1  request; the master holds it high until it sees ready.
- dividerres  output  WIDTH  quotient; held stable from ready rise until the next accepted request.
- remainder  output  WIDTH  final remainder; same hold rules as dividerres.
- busy  output  1  high while iterating.
- ready  output  1  high in DONE; result valid.
- div_zero  output  1  divisor was 0 for the current result; same hold rules as dividerres.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - busy, ready, div_zero, dividerres and remainder all go to 0.
  - Iteration counter and internal registers are cleared.
  - Reset mid-RUN or mid-DONE aborts the division; no result is produced.
- States: IDLE, RUN, (ROUND, only with the optional feature), DONE.
- IDLE:
  - busy=0, ready=0.
  - On an edge with start_div=1: latch dividend and divisor, clear the partial remainder, load the counter with WIDTH, set div_zero to (divisor==0), set busy to 1, go to RUN.
  - Operands are sampled only at this edge; later changes on dividerbus are ignored.
- RUN, one iteration per edge:
  - Shift {partial remainder, dividend} left by 1.
  - If the shifted remainder (WIDTH+1 bits) is >= divisor: subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter.
  - On the edge where the counter goes 1→0: write dividerres and remainder, set busy to 0 and ready to 1, go to DONE (or ROUND with the optional feature).
- Timing:
  - busy is high for exactly WIDTH cycles.
  - ready rises WIDTH+1 edges after the accepting edge (17 for the default width).
- Divide by zero:
  - No special path; the full WIDTH iterations run.
  - Restoring division naturally yields quotient all-ones and remainder = dividend.
  - div_zero=1. busy still pulses, so masters that wait for busy=1 before polling ready do not hang.
- DONE:
  - ready=1, busy=0, outputs held.
  - While start_div stays 1, remain in DONE; a held request is never re-accepted.
  - On an edge with start_div=0: ready goes to 0, state goes to IDLE.
  - dividerres, remainder and div_zero keep their values until the next acceptance.
- start_div dropping during RUN: ignored; the division completes. If start_div is already 0 on entry to DONE, ready is high for exactly one cycle.
- Back-to-back requests: after a DONE→IDLE transition, a start_div=1 on the next edge is accepted. Minimum spacing between acceptances is WIDTH+2 edges.
- All arithmetic is unsigned.
- No overflow is possible: the quotient fits in WIDTH bits because the dividend is WIDTH bits.

Optional Feature:
- Macro: SHARED_DIVIDER_ROUND_EN.
- Defined:
  - Extra ROUND state after RUN; busy stays 1 through ROUND (WIDTH+1 busy cycles).
  - In ROUND: if 2*remainder >= divisor, the quotient is incremented, saturating at all-ones. A half-way result rounds up.
  - div_zero results are not incremented.
  - ready rises WIDTH+2 edges after acceptance.
  - The remainder output keeps the unrounded remainder.
- Undefined: quotient is truncated; no ROUND state; timing as stated above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with start_div=0 → busy=0, ready=0, dividerres=0, div_zero=0 for 20 cycles.
- Basic division: dividerbus={16'd1000,16'd7}, start_div held → busy high for 16 cycles, then ready=1, dividerres=142, remainder=6. With the macro: dividerres=143, ready at edge 18.
- Divide by zero: {16'd500,16'd0} → busy pulses 16 cycles, dividerres=16'hFFFF, remainder=500, div_zero=1. With the macro the result is still 16'hFFFF.
- Half-way rounding: {16'd5,16'd10} → 0 without the macro, 1 with it. Saturation case {16'hFFFF,16'd1} → 16'hFFFF in both builds.
- Handshake:
  - start_div held 10 cycles after ready → ready stays 1 and no new busy pulse.
  - Drop start_div → ready falls next edge.
  - Reassert with {16'd100,16'd3} → dividerres=33 after 17 edges.
  - Operands changed during RUN have no effect.
- Reset mid-operation: assert rst_n=0 at RUN iteration 8 → next edge busy=0, ready=0, outputs 0; a new request then completes correctly.
